// File: rtl/joystick_adc_reader.sv
// ---------------------------------------------------------------------------
// joystick_adc_reader
//
// SPI master front end for a 2-channel, 12-bit MCP3202-style ADC. Frames
// alternate between channel 0 (X axis) and channel 1 (Y axis). The most
// recent code for each axis is held in a register. sample_valid pulses
// whenever the Y register is written, which completes an X/Y pair.
//
// Frame layout (cs_n low for 36*CLK_DIV cycles):
//   SETUP : CLK_DIV cycles with sclk low. mosi carries the start bit.
//   SHIFT : 17 sclk periods. Each period is CLK_DIV cycles low, then
//           CLK_DIV cycles high. Bits are indexed 0..16.
//   HOLD  : CLK_DIV cycles with sclk low. The axis register is written on
//           entry to this state.
//   GAP   : GAP_CYCLES cycles with cs_n high. enable is sampled at the end.
//
// Parameters:
//   CLK_DIV     clk cycles per SCLK half-period (>= 2)
//   GAP_CYCLES  clk cycles with cs_n high between frames (>= 1)
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   enable        run continuous conversions while high
//   adc_miso      ADC data out
//   adc_sclk      SPI clock, mode 0, idles low
//   adc_mosi      ADC command in
//   adc_cs_n      ADC chip select, active low
//   x_axis_out    latest channel-0 code
//   y_axis_out    latest channel-1 code
//   sample_valid  1-cycle pulse when y_axis_out updates
//   busy          high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module joystick_adc_reader #(
  parameter int CLK_DIV    = 25,
  parameter int GAP_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_sclk,
  output logic        adc_mosi,
  output logic        adc_cs_n,
  output logic [11:0] x_axis_out,
  output logic [11:0] y_axis_out,
  output logic        sample_valid,
  output logic        busy
);

  // One phase counter serves SETUP, the SHIFT half-periods, HOLD and GAP.
  // It is sized for the longest of those phases.
  localparam int CNT_MAX = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  localparam int         FRAME_BITS     = 17;
  localparam logic [4:0] LAST_BIT       = 5'(FRAME_BITS - 1);
  // Index 4 is the ADC null bit. Data bits B11..B0 occupy indices 5..16.
  localparam logic [4:0] FIRST_DATA_BIT = 5'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [4:0]         bit_idx_reg, bit_idx_next;
  logic               sclk_reg, sclk_next;
  logic               mosi_reg, mosi_next;
  logic               cs_n_reg, cs_n_next;
  logic [11:0]        shreg_reg, shreg_next;
  logic [11:0]        x_reg, x_next;
  logic [11:0]        y_reg, y_next;
  logic               valid_reg, valid_next;
  logic               busy_reg, busy_next;
  logic               chan_reg, chan_next;

  logic               div_done;
  logic               gap_done;
  logic               rise_evt;
  logic               fall_evt;
  logic               last_bit;
  logic               hold_entry;
  logic [4:0]         bit_idx_inc;
  logic [FRAME_BITS-1:0] cmd_bits;

  // Command word, indexed by frame bit. The layout is:
  //   bit 0 = start, bit 1 = single-ended, bit 2 = channel,
  //   bit 3 = MSB-first, and bits 4..16 are don't-care, sent as 0.
  generate
    for (genvar gi = 0; gi < FRAME_BITS; gi++) begin : g_cmd
      if (gi == 2) begin : g_chan
        assign cmd_bits[gi] = chan_reg;
      end else if (gi <= 3) begin : g_one
        assign cmd_bits[gi] = 1'b1;
      end else begin : g_zero
        assign cmd_bits[gi] = 1'b0;
      end
    end
  endgenerate

  assign div_done    = (cnt_reg == DIV_LAST);
  assign gap_done    = (cnt_reg == GAP_LAST);
  assign last_bit    = (bit_idx_reg == LAST_BIT);
  assign bit_idx_inc = bit_idx_reg + 5'd1;
  // Half-period boundaries inside SHIFT: a low half ends with a rising
  // sclk edge, and a high half ends with a falling one.
  assign rise_evt    = (state_reg == SHIFT) && div_done && !sclk_reg;
  assign fall_evt    = (state_reg == SHIFT) && div_done &&  sclk_reg;
  assign hold_entry  = (state_reg == SHIFT) && (state_next == HOLD);

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      cs_n_reg    <= 1'b1;
      shreg_reg   <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      chan_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      cs_n_reg    <= cs_n_next;
      shreg_reg   <= shreg_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      valid_reg   <= valid_next;
      busy_reg    <= busy_next;
      chan_reg    <= chan_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable)              state_next = SETUP;
      SETUP:   if (div_done)            state_next = SHIFT;
      SHIFT:   if (fall_evt && last_bit) state_next = HOLD;
      HOLD:    if (div_done)            state_next = GAP;
      GAP:     if (gap_done)            state_next = enable ? SETUP : IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath logic. Every output is computed from state_next, so
  // the registered pins change on the same edge as the state.
  // -------------------------------------------------------------------------
  always_comb begin
    // Phase counter: restart on every state change and at each SHIFT
    // half-period boundary. Hold at zero while idle.
    cnt_next = cnt_reg + CNT_W'(1);
    if ((state_next != state_reg) || (state_reg == IDLE) ||
        ((state_reg == SHIFT) && div_done)) begin
      cnt_next = '0;
    end

    // sclk toggles only at half-period boundaries inside SHIFT. It is
    // forced low everywhere else, so the 17th falling edge coincides with
    // entry to HOLD.
    sclk_next = 1'b0;
    if ((state_reg == SHIFT) && (state_next == SHIFT)) begin
      sclk_next = div_done ? ~sclk_reg : sclk_reg;
    end

    bit_idx_next = bit_idx_reg;
    if (state_reg != SHIFT) begin
      bit_idx_next = '0;
    end else if (fall_evt && !last_bit) begin
      bit_idx_next = bit_idx_inc;
    end

    // mosi only changes at the start of a low half, which is the falling
    // edge of the previous bit. The start bit is presented during SETUP.
    case (state_next)
      SETUP:   mosi_next = cmd_bits[0];
      SHIFT:   mosi_next = fall_evt ? cmd_bits[bit_idx_inc] : mosi_reg;
      default: mosi_next = 1'b0;
    endcase

    cs_n_next = !((state_next == SETUP) || (state_next == SHIFT) ||
                  (state_next == HOLD));
    busy_next = (state_next != IDLE);

    // Clear at frame start so no bits carry over from an earlier frame.
    // Sample on the rising sclk edge for the data indices only.
    shreg_next = shreg_reg;
    if ((state_next == SETUP) && (state_reg != SETUP)) begin
      shreg_next = '0;
    end else if (rise_evt && (bit_idx_reg >= FIRST_DATA_BIT)) begin
      shreg_next = {shreg_reg[10:0], adc_miso};
    end

    x_next     = x_reg;
    y_next     = y_reg;
    valid_next = 1'b0;
    if (hold_entry) begin
      if (chan_reg) begin
        y_next     = shreg_reg;
        valid_next = 1'b1;
      end else begin
        x_next     = shreg_reg;
      end
    end

    // The channel alternates per frame. Any return to IDLE restarts the
    // next run on X, even when only the X half of a pair completed.
    chan_next = chan_reg;
    if (state_next == IDLE) begin
      chan_next = 1'b0;
    end else if (hold_entry) begin
      chan_next = ~chan_reg;
    end
  end

  assign adc_sclk     = sclk_reg;
  assign adc_mosi     = mosi_reg;
  assign adc_cs_n     = cs_n_reg;
  assign x_axis_out   = x_reg;
  assign y_axis_out   = y_reg;
  assign sample_valid = valid_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_joystick_adc_reader.sv
// ---------------------------------------------------------------------------
// tb_joystick_adc_reader
//
// Bench for joystick_adc_reader with CLK_DIV=2 and GAP_CYCLES=4.
//
// A behavioural ADC model watches sclk, cs_n and mosi. It decodes the
// channel from command bit 2 and drives the null bit followed by
// B11..B0 of the code configured for that channel.
//
// Expected axis updates and expected command nibbles are pushed to
// queues. Each scenario task pops and compares them as the DUT completes
// frames.
// ---------------------------------------------------------------------------
module tb_joystick_adc_reader;

  localparam int CLK_DIV    = 2;
  localparam int GAP_CYCLES = 4;
  localparam int FRAME_LOW  = 36 * CLK_DIV;
  localparam int TIMEOUT    = 400;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        enable   = 1'b0;
  logic        adc_miso = 1'b0;
  logic        adc_sclk;
  logic        adc_mosi;
  logic        adc_cs_n;
  logic [11:0] x_axis_out;
  logic [11:0] y_axis_out;
  logic        sample_valid;
  logic        busy;

  joystick_adc_reader #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .adc_miso     (adc_miso),
    .adc_sclk     (adc_sclk),
    .adc_mosi     (adc_mosi),
    .adc_cs_n     (adc_cs_n),
    .x_axis_out   (x_axis_out),
    .y_axis_out   (y_axis_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          chan;
    logic [11:0] code;
  } upd_t;

  upd_t       upd_q[$];
  logic [3:0] frame_q[$];

  // ADC model configuration
  logic [11:0] ch0_code = 12'h000;
  logic [11:0] ch1_code = 12'h000;

  // Monitor state
  int          rises        = 0;
  bit          prev_sclk    = 1'b0;
  bit          prev_cs      = 1'b1;
  bit          prev_valid   = 1'b0;
  bit          model_chan   = 1'b0;
  logic [3:0]  cmd_seen     = 4'h0;
  logic [11:0] code_sel;
  int          low_len      = 0;
  int          high_len     = 0;
  int          gap_len      = 0;
  int          since_rise   = 0;
  int          rise_gap     = 0;
  int          upd_cnt      = 0;
  bit          upd_valid    = 1'b0;
  int          valid_total  = 0;
  int          valid_double = 0;
  int          frame_cnt    = 0;
  logic [3:0]  frame_cmd    = 4'h0;
  int          frame_rises  = 0;
  int          frame_low    = 0;

  // Monitor and ADC model. The process samples 1 time unit after each
  // rising edge, then sets miso for the next rising sclk edge.
  always begin
    @(posedge clk);
    #1;
    since_rise++;
    if (!rst_n) begin
      rises    = 0;
      low_len  = 0;
      high_len = 0;
    end else if (!adc_cs_n) begin
      if (prev_cs) begin
        gap_len = high_len;
        low_len = 0;
        rises   = 0;
      end
      low_len++;
      if (adc_sclk && !prev_sclk) begin
        if (rises < 4) cmd_seen = {cmd_seen[2:0], adc_mosi};
        if (rises == 2) model_chan = adc_mosi;
        rise_gap   = since_rise;
        since_rise = 0;
        rises++;
      end
      if (prev_sclk && !adc_sclk && rises == 17) begin
        upd_cnt++;
        upd_valid = sample_valid;
      end
    end else begin
      if (!prev_cs) begin
        frame_cnt++;
        frame_cmd   = cmd_seen;
        frame_rises = rises;
        frame_low   = low_len;
        high_len    = 0;
      end
      high_len++;
    end
    if (sample_valid) valid_total++;
    if (sample_valid && prev_valid) valid_double++;
    prev_valid = sample_valid;
    prev_sclk  = adc_sclk;
    prev_cs    = rst_n ? adc_cs_n : 1'b1;
    code_sel   = model_chan ? ch1_code : ch0_code;
    if (!adc_cs_n && rises >= 5 && rises <= 16) adc_miso = code_sel[4'(16 - rises)];
    else adc_miso = 1'b0;
  end

  // ---------------- wait helpers (bounded) ----------------
  task automatic wait_upd(input int prev, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (upd_cnt != prev) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_frame(input int prev, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (frame_cnt != prev) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_shift(input int min_rise, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      if (!adc_cs_n && rises >= min_rise && rises < 17) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (adc_cs_n !== 1'b1) $display("FAIL reset_cs_n: got %b want 1", adc_cs_n); else n_pass++;
    n_checks++; if (adc_sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", adc_sclk); else n_pass++;
    n_checks++; if (adc_mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", adc_mosi); else n_pass++;
    n_checks++; if (x_axis_out !== 12'd0) $display("FAIL reset_x: got %h want 000", x_axis_out); else n_pass++;
    n_checks++; if (y_axis_out !== 12'd0) $display("FAIL reset_y: got %h want 000", y_axis_out); else n_pass++;
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", sample_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pair(input logic [11:0] c0, input logic [11:0] c1, input string name);
    bit          ok;
    upd_t        e;
    int          v0;
    int          prev;
    logic [11:0] got;
    ch0_code = c0;
    ch1_code = c1;
    upd_q.push_back('{1'b0, c0});
    upd_q.push_back('{1'b1, c1});
    v0     = valid_total;
    prev   = upd_cnt;
    enable = 1'b1;
    while (upd_q.size() > 0) begin
      wait_upd(prev, ok);
      prev = upd_cnt;
      e    = upd_q.pop_front();
      n_checks++;
      if (!ok) begin
        $display("FAIL %s_timeout: no update for ch%0d within %0d cycles", name, e.chan, TIMEOUT);
        upd_q.delete();
        break;
      end
      n_pass++;
      got = e.chan ? y_axis_out : x_axis_out;
      $display("%s: ch%0d code=%h valid=%b", name, e.chan, got, upd_valid);
      n_checks++;
      if (got !== e.code) $display("FAIL %s_code_ch%0d: got %h want %h", name, e.chan, got, e.code);
      else n_pass++;
      n_checks++;
      if (upd_valid !== e.chan) $display("FAIL %s_valid_ch%0d: got %b want %b", name, e.chan, upd_valid, e.chan);
      else n_pass++;
    end
    enable = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL %s_idle: busy=%b want 0", name, busy); else n_pass++;
    n_checks++;
    if (valid_total - v0 != 1) $display("FAIL %s_pulses: got %0d want 1", name, valid_total - v0);
    else n_pass++;
    n_checks++;
    if (valid_double != 0) $display("FAIL %s_double_valid: got %0d want 0", name, valid_double);
    else n_pass++;
  endtask

  task automatic test_framing();
    bit         ok;
    int         prev;
    logic [3:0] exp_cmd;
    frame_q.push_back(4'b1101);
    frame_q.push_back(4'b1111);
    frame_q.push_back(4'b1101);
    prev   = frame_cnt;
    enable = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (adc_cs_n !== 1'b0) $display("FAIL start_cs_n: got %b want 0", adc_cs_n); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else n_pass++;
    for (int f = 0; f < 3; f++) begin
      wait_frame(prev, ok);
      prev    = frame_cnt;
      exp_cmd = frame_q.pop_front();
      n_checks++;
      if (!ok) begin
        $display("FAIL frame%0d_timeout: no frame end within %0d cycles", f, TIMEOUT);
        break;
      end
      n_pass++;
      $display("frame%0d: cmd=%b rises=%0d cs_low=%0d gap=%0d sclk_per=%0d", f, frame_cmd, frame_rises, frame_low, gap_len, rise_gap);
      n_checks++; if (frame_cmd !== exp_cmd) $display("FAIL frame%0d_cmd: got %b want %b", f, frame_cmd, exp_cmd); else n_pass++;
      n_checks++; if (frame_rises != 17) $display("FAIL frame%0d_rises: got %0d want 17", f, frame_rises); else n_pass++;
      n_checks++; if (frame_low != FRAME_LOW) $display("FAIL frame%0d_cs_low: got %0d want %0d", f, frame_low, FRAME_LOW); else n_pass++;
      n_checks++; if (rise_gap != 2 * CLK_DIV) $display("FAIL frame%0d_sclk_period: got %0d want %0d", f, rise_gap, 2 * CLK_DIV); else n_pass++;
      if (f > 0) begin
        n_checks++;
        if (gap_len != GAP_CYCLES) $display("FAIL frame%0d_gap: got %0d want %0d", f, gap_len, GAP_CYCLES);
        else n_pass++;
      end
    end
    frame_q.delete();
    enable = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL framing_idle: busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_enable_drop();
    bit   ok;
    int   prev;
    int   v0;
    upd_t e;
    ch0_code = 12'h123;
    ch1_code = 12'h321;
    v0       = valid_total;
    prev     = upd_cnt;
    enable   = 1'b1;
    wait_shift(6, ok);
    n_checks++; if (!ok) $display("FAIL drop_shift_timeout: frame never reached SHIFT"); else n_pass++;
    enable = 1'b0;
    upd_q.push_back('{1'b0, 12'h123});
    wait_upd(prev, ok);
    e = upd_q.pop_front();
    $display("drop: ch%0d x=%h valid=%b", e.chan, x_axis_out, upd_valid);
    n_checks++; if (!ok) $display("FAIL drop_upd_timeout: X frame did not finish"); else n_pass++;
    n_checks++; if (x_axis_out !== e.code) $display("FAIL drop_x: got %h want %h", x_axis_out, e.code); else n_pass++;
    n_checks++; if (upd_valid !== 1'b0) $display("FAIL drop_valid_at_hold: got %b want 0", upd_valid); else n_pass++;
    wait_idle(ok);
    repeat (100) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (adc_cs_n !== 1'b1) $display("FAIL drop_cs_n: got %b want 1", adc_cs_n); else n_pass++;
    n_checks++; if (valid_total != v0) $display("FAIL drop_no_pulse: got %0d pulses want 0", valid_total - v0); else n_pass++;
    n_checks++; if (upd_cnt != prev + 1) $display("FAIL drop_frames: got %0d updates want 1", upd_cnt - prev); else n_pass++;
    // Re-enable: the next frame must address channel 0 again.
    frame_q.push_back(4'b1101);
    prev   = frame_cnt;
    enable = 1'b1;
    wait_frame(prev, ok);
    enable = 1'b0;
    n_checks++; if (!ok) $display("FAIL reenable_timeout: no frame"); else n_pass++;
    n_checks++;
    if (frame_cmd !== frame_q[0]) $display("FAIL reenable_cmd: got %b want %b", frame_cmd, frame_q[0]);
    else n_pass++;
    $display("reenable: cmd=%b", frame_cmd);
    void'(frame_q.pop_front());
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int prev;
    ch0_code = 12'h456;
    ch1_code = 12'h654;
    prev     = upd_cnt;
    enable   = 1'b1;
    wait_upd(prev, ok);
    n_checks++; if (!ok) $display("FAIL rmid_x_timeout: no X update"); else n_pass++;
    wait_shift(5, ok);
    n_checks++; if (!ok) $display("FAIL rmid_shift_timeout: Y frame not in SHIFT"); else n_pass++;
    // Assert reset between clock edges and check before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    $display("rmid: cs_n=%b sclk=%b mosi=%b x=%h y=%h busy=%b", adc_cs_n, adc_sclk, adc_mosi, x_axis_out, y_axis_out, busy);
    n_checks++; if (adc_cs_n !== 1'b1) $display("FAIL rmid_cs_n: got %b want 1", adc_cs_n); else n_pass++;
    n_checks++; if (adc_sclk !== 1'b0) $display("FAIL rmid_sclk: got %b want 0", adc_sclk); else n_pass++;
    n_checks++; if (adc_mosi !== 1'b0) $display("FAIL rmid_mosi: got %b want 0", adc_mosi); else n_pass++;
    n_checks++; if (x_axis_out !== 12'd0) $display("FAIL rmid_x: got %h want 000", x_axis_out); else n_pass++;
    n_checks++; if (y_axis_out !== 12'd0) $display("FAIL rmid_y: got %h want 000", y_axis_out); else n_pass++;
    n_checks++; if (sample_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", sample_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    repeat (3) @(negedge clk);
    frame_q.push_back(4'b1101);
    upd_q.push_back('{1'b0, 12'h456});
    prev  = frame_cnt;
    rst_n = 1'b1;
    wait_frame(prev, ok);
    enable = 1'b0;
    n_checks++; if (!ok) $display("FAIL rmid_frame_timeout: no frame after release"); else n_pass++;
    $display("rmid_restart: cmd=%b x=%h", frame_cmd, x_axis_out);
    n_checks++;
    if (frame_cmd !== frame_q[0]) $display("FAIL rmid_cmd: got %b want %b", frame_cmd, frame_q[0]);
    else n_pass++;
    n_checks++;
    if (x_axis_out !== upd_q[0].code) $display("FAIL rmid_x_after: got %h want %h", x_axis_out, upd_q[0].code);
    else n_pass++;
    void'(frame_q.pop_front());
    void'(upd_q.pop_front());
    wait_idle(ok);
  endtask

  task automatic test_stability();
    int glitches = 0;
    enable   = 1'b0;
    ch0_code = 12'hFFF;
    ch1_code = 12'hFFF;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (adc_cs_n !== 1'b1 || x_axis_out !== 12'h456 || y_axis_out !== 12'h000 ||
          busy !== 1'b0 || sample_valid !== 1'b0) glitches++;
    end
    $display("stable: x=%h y=%h cs_n=%b glitches=%0d", x_axis_out, y_axis_out, adc_cs_n, glitches);
    n_checks++; if (x_axis_out !== 12'h456) $display("FAIL stable_x: got %h want 456", x_axis_out); else n_pass++;
    n_checks++; if (y_axis_out !== 12'h000) $display("FAIL stable_y: got %h want 000", y_axis_out); else n_pass++;
    n_checks++; if (adc_cs_n !== 1'b1) $display("FAIL stable_cs_n: got %b want 1", adc_cs_n); else n_pass++;
    n_checks++; if (glitches != 0) $display("FAIL stable_glitches: got %0d want 0", glitches); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pair(12'h3E8, 12'hBB8, "pair_1000_3000");
    test_pair(12'h000, 12'hFFF, "pair_0_4095");
    test_pair(12'hA5A, 12'h5A5, "pair_alt");
    test_framing();
    test_enable_drop();
    test_reset_mid();
    test_stability();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
